// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared definitions for the regfile_mp register file slice.
//
// Contents:
//   DEF_XLEN / DEF_NREGS : default data width and architectural register count
//   PAR_MAX_W            : widest data word the parity helper accepts
//   clog2_aw()           : register-address width for a given register count
//   parity_even()        : even-parity bit of a (zero-extended) data word
//
// Optional feature macro used by the files importing this package:
//   REGFILE_PARITY_EN    : per-register parity storage and rd_perr outputs

package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;

  // Callers zero-extend their data to this width; zero bits do not change
  // parity, so one helper serves every XLEN up to 64.
  localparam int PAR_MAX_W = 64;

  // Address width; never below 1 so a two-entry file still has an address bit.
  function automatic int clog2_aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bit that makes data plus parity contain an even number of ones.
  function automatic logic parity_even(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if -- bus between decode/writeback (master) and the register
// file (slave).
//
// Signals:
//   rd_addr  [NRD*AW]   read addresses, port k in [k*AW +: AW]
//   rd_data  [NRD*XLEN] read data, port k in [k*XLEN +: XLEN]
//   rd_busy  [NRD]      busy flag of the register addressed by port k
//   rd_perr  [NRD]      stored-parity error per read port (REGFILE_PARITY_EN only)
//   wr_en    [NWR]      write enable per write port
//   wr_addr  [NWR*AW]   write addresses
//   wr_data  [NWR*XLEN] write data
//   rsv_en / rsv_addr   reserve request: mark rsv_addr busy
//   flush               clear all busy bits

interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN  = DEF_XLEN,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);

  localparam int AW = clog2_aw(NREGS);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
`ifdef REGFILE_PARITY_EN
  logic [NRD-1:0]      rd_perr;
`endif
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                rsv_en;
  logic [AW-1:0]       rsv_addr;
  logic                flush;

`ifdef REGFILE_PARITY_EN
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, rd_perr
  );
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, rd_perr
  );
`else
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy
  );
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy
  );
`endif

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard -- one busy bit per architectural register.
//
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   clr_mask   registers receiving a committed write this cycle
//   set_mask   register being reserved this cycle
//   flush      clear every busy bit; overrides set_mask
//   rd_addr    flattened read addresses, port k in [k*AW +: AW]
//   rd_busy    stored busy bit of each addressed register (pre-edge value)
//
// The caller has already removed register 0 from both masks when it is
// hardwired, so this block needs no knowledge of ZERO_REG.

module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = DEF_NREGS,
  parameter  int NRD   = 2,
  localparam int AW    = clog2_aw(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREGS-1:0]  clr_mask,
  input  logic [NREGS-1:0]  set_mask,
  input  logic              flush,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREGS-1:0] busy_q;

  // Set is applied after clear: a reservation issued alongside the write
  // completing the previous producer leaves the register busy.
  // NOTE: state updates use <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else if (flush) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~clr_mask) | set_mask;
    end
  end

  // NOTE: a default assignment heads every always_comb so no path infers a latch.
  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_busy[k] = busy_q[rd_addr[k*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp -- parametrised multi-port integer register file with busy
// scoreboard and optional write-to-read bypass.
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset; clears data, parity and busy bits
//   bus   regfile_mp_if.slave: NRD combinational read ports (data, busy and,
//         with REGFILE_PARITY_EN defined, parity error), NWR write ports,
//         reservation request and flush
//
// Parameters: XLEN, NREGS (power of two), NRD (1..4), NWR (1..2),
//   BYPASS (forward same-cycle write data to reads), ZERO_REG (x0 reads zero,
//   is never busy, ignores writes and reservations).
//
// Optional feature: define REGFILE_PARITY_EN to store an even-parity bit per
// register and drive rd_perr. XLEN must not exceed PAR_MAX_W in that build.

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  localparam int AW = clog2_aw(NREGS);

  logic [XLEN-1:0]  mem_q [NREGS];
`ifdef REGFILE_PARITY_EN
  logic             par_q [NREGS];
`endif

  // Unpacked write-port fields, qualified enables and scoreboard masks.
  logic [AW-1:0]    wa [NWR];
  logic [XLEN-1:0]  wd [NWR];
  logic [NWR-1:0]   wr_ok;
  logic             rsv_ok;
  logic [NREGS-1:0] wr_mask;
  logic [NREGS-1:0] rsv_mask;
  logic [NRD-1:0]   sb_busy;

  always_comb begin
    wr_mask  = '0;
    rsv_mask = '0;
    wr_ok    = '0;
    for (int j = 0; j < NWR; j++) begin
      wa[j]    = bus.wr_addr[j*AW +: AW];
      wd[j]    = bus.wr_data[j*XLEN +: XLEN];
      wr_ok[j] = bus.wr_en[j] && !(ZERO_REG != 0 && wa[j] == '0);
      if (wr_ok[j]) begin
        wr_mask[wa[j]] = 1'b1;
      end
    end
    rsv_ok = bus.rsv_en && !(ZERO_REG != 0 && bus.rsv_addr == '0);
    if (rsv_ok) begin
      rsv_mask[bus.rsv_addr] = 1'b1;
    end
  end

  // Later write ports are visited last, so on an address conflict the
  // highest-index port's assignment is the one that lands.
  // NOTE: the array is built from flops and must read zero straight out of
  // reset, so it takes the asynchronous reset like any other state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
`ifdef REGFILE_PARITY_EN
        par_q[i] <= 1'b0;
`endif
      end
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_ok[j]) begin
          mem_q[wa[j]] <= wd[j];
`ifdef REGFILE_PARITY_EN
          par_q[wa[j]] <= parity_even(PAR_MAX_W'(wd[j]));
`endif
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .clr_mask (wr_mask),
    .set_mask (rsv_mask),
    .flush    (bus.flush),
    .rd_addr  (bus.rd_addr),
    .rd_busy  (sb_busy)
  );

  // Read ports. Forwarding is suppressed while rst is high so reads show the
  // cleared array rather than a write that reset will discard.
  logic [NRD*XLEN-1:0] rd_data_w;
  logic [NRD-1:0]      rd_busy_w;
  logic [NRD-1:0]      rd_perr_w;

  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rdat;
    logic            hit;
    rd_data_w = '0;
    rd_busy_w = '0;
    rd_perr_w = '0;
    ra        = '0;
    rdat      = '0;
    hit       = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      ra   = bus.rd_addr[k*AW +: AW];
      rdat = mem_q[ra];
      hit  = 1'b0;
      if (BYPASS != 0 && !rst) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_ok[j] && wa[j] == ra) begin
            rdat = wd[j];
            hit  = 1'b1;
          end
        end
      end
      // A forwarded value retires its producer, unless a new producer is
      // being reserved for the same register right now.
      rd_busy_w[k] = hit ? (rsv_ok && !rst && bus.rsv_addr == ra) : sb_busy[k];
`ifdef REGFILE_PARITY_EN
      rd_perr_w[k] = !hit && (parity_even(PAR_MAX_W'(mem_q[ra])) != par_q[ra]);
`endif
      if (ZERO_REG != 0 && ra == '0) begin
        rdat         = '0;
        rd_busy_w[k] = 1'b0;
        rd_perr_w[k] = 1'b0;
      end
      rd_data_w[k*XLEN +: XLEN] = rdat;
    end
  end

  assign bus.rd_data = rd_data_w;
  assign bus.rd_busy = rd_busy_w;
`ifdef REGFILE_PARITY_EN
  assign bus.rd_perr = rd_perr_w;
`else
  logic unused_perr;
  assign unused_perr = ^rd_perr_w;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp -- directed self-checking bench for regfile_mp.
// Expected read results are queued as each step is driven and compared once
// the combinational outputs have settled, away from the rising clock edge.

module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = clog2_aw(NREGS);

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp #(
    .XLEN     (XLEN),
    .NREGS    (NREGS),
    .NRD      (NRD),
    .NWR      (NWR),
    .BYPASS   (1),
    .ZERO_REG (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string           tag;
    int              port;
    logic [XLEN-1:0] data;
    logic            busy;
    logic            perr;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_rd(input string tag, input int k, input logic [XLEN-1:0] d,
                           input logic b, input logic p = 1'b0);
    exp_t e;
    e.tag  = tag;
    e.port = k;
    e.data = d;
    e.busy = b;
    e.perr = p;
    sb_q.push_back(e);
  endtask

  task automatic compare_all();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.tag, "/data"}, bus.rd_data[e.port*XLEN +: XLEN], e.data);
      check({e.tag, "/busy"}, XLEN'(bus.rd_busy[e.port]), XLEN'(e.busy));
`ifdef REGFILE_PARITY_EN
      check({e.tag, "/perr"}, XLEN'(bus.rd_perr[e.port]), XLEN'(e.perr));
`endif
    end
  endtask

  task automatic idle();
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic rd(input int k, input int a);
    bus.rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic wr(input int j, input int a, input logic [XLEN-1:0] d);
    bus.wr_en[j]                = 1'b1;
    bus.wr_addr[j*AW +: AW]     = AW'(a);
    bus.wr_data[j*XLEN +: XLEN] = d;
  endtask

  task automatic rsv(input int a);
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = AW'(a);
  endtask

  // Start of a step: inputs change on the falling edge.
  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  // Let combinational reads settle, then score, well before the rising edge.
  task automatic settle();
    #2;
    compare_all();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    bus.rd_addr = '0;

    // Reset state.
    cyc(); rd(0, 5); rd(1, 7);
    expect_rd("reset_x5", 0, 32'h0, 1'b0);
    expect_rd("reset_x7", 1, 32'h0, 1'b0);
    settle();
    cyc(); rst = 1'b0;

    // Basic write with same-cycle bypass, then stored read.
    cyc(); wr(0, 5, 32'hDEADBEEF); rd(0, 5); rd(1, 5);
    expect_rd("byp_x5_p0", 0, 32'hDEADBEEF, 1'b0);
    expect_rd("byp_x5_p1", 1, 32'hDEADBEEF, 1'b0);
    settle();
    cyc(); rd(0, 5);
    expect_rd("rd_x5", 0, 32'hDEADBEEF, 1'b0);
    settle();

    // Register 0 ignores writes and never forwards.
    cyc(); wr(0, 0, 32'h00001234); rd(0, 0);
    expect_rd("wr_x0_same", 0, 32'h0, 1'b0);
    settle();
    cyc(); rd(0, 0);
    expect_rd("rd_x0", 0, 32'h0, 1'b0);
    settle();

    // Dual-write conflict: port 1 wins, also on the bypass path.
    cyc(); wr(0, 7, 32'hAAAA0000); wr(1, 7, 32'h5555FFFF); rd(1, 7);
    expect_rd("dual_byp", 1, 32'h5555FFFF, 1'b0);
    settle();
    cyc(); rd(0, 7);
    expect_rd("dual_x7", 0, 32'h5555FFFF, 1'b0);
    settle();

    // Scoreboard: reserve, then write clears, then write+reserve stays busy.
    cyc(); rsv(3); rd(0, 3);
    expect_rd("rsv_same", 0, 32'h0, 1'b0);
    settle();
    cyc(); rd(0, 3); rd(1, 3);
    expect_rd("rsv_busy_p0", 0, 32'h0, 1'b1);
    expect_rd("rsv_busy_p1", 1, 32'h0, 1'b1);
    settle();
    cyc(); wr(1, 3, 32'h00000033); rd(0, 3);
    expect_rd("wr3_byp", 0, 32'h00000033, 1'b0);
    settle();
    cyc(); rd(0, 3);
    expect_rd("wr3_clr", 0, 32'h00000033, 1'b0);
    settle();
    cyc(); wr(0, 3, 32'h00000044); rsv(3); rd(0, 3);
    expect_rd("wrrsv_byp", 0, 32'h00000044, 1'b1);
    settle();
    cyc(); rd(0, 3);
    expect_rd("wrrsv_busy", 0, 32'h00000044, 1'b1);
    settle();

    // Flush: fill x1/x2/x4, reserve them, then flush with a competing reserve.
    cyc(); wr(0, 1, 32'h11111111); wr(1, 2, 32'h22222222);
    cyc(); wr(0, 4, 32'h44444444);
    cyc(); rsv(1);
    cyc(); rsv(2);
    cyc(); rsv(4); rd(0, 1); rd(1, 2);
    expect_rd("pre_flush_x1", 0, 32'h11111111, 1'b1);
    expect_rd("pre_flush_x2", 1, 32'h22222222, 1'b1);
    settle();
    cyc(); bus.flush = 1'b1; rsv(9); rd(0, 4); rd(1, 9);
    expect_rd("pre_flush_x4", 0, 32'h44444444, 1'b1);
    expect_rd("flush_cyc_x9", 1, 32'h0, 1'b0);
    settle();
    cyc(); rd(0, 1); rd(1, 2);
    expect_rd("flush_x1", 0, 32'h11111111, 1'b0);
    expect_rd("flush_x2", 1, 32'h22222222, 1'b0);
    settle();
    cyc(); rd(0, 4); rd(1, 9);
    expect_rd("flush_x4", 0, 32'h44444444, 1'b0);
    expect_rd("flush_x9", 1, 32'h0, 1'b0);
    settle();
    cyc(); rd(0, 3);
    expect_rd("flush_x3", 0, 32'h00000044, 1'b0);
    settle();

    // Mid-cycle asynchronous reset with nonzero contents and a busy register.
    cyc(); rsv(5);
    cyc(); rd(0, 5); rd(1, 7);
    expect_rd("pre_rst_x5", 0, 32'hDEADBEEF, 1'b1);
    expect_rd("pre_rst_x7", 1, 32'h5555FFFF, 1'b0);
    settle();
    #1;
    rst = 1'b1;
    wr(0, 5, 32'h0F0F0F0F);
    #1;
    expect_rd("rst_async_x5", 0, 32'h0, 1'b0);
    expect_rd("rst_async_x7", 1, 32'h0, 1'b0);
    compare_all();
    for (int c = 0; c < 3; c++) begin
      cyc(); wr(0, 5, 32'h0F0F0F0F); rsv(7);
      expect_rd("rst_hold_x5", 0, 32'h0, 1'b0);
      expect_rd("rst_hold_x7", 1, 32'h0, 1'b0);
      settle();
    end
    cyc(); rst = 1'b0;
    expect_rd("post_rst_x5", 0, 32'h0, 1'b0);
    expect_rd("post_rst_x7", 1, 32'h0, 1'b0);
    settle();

`ifdef REGFILE_PARITY_EN
    // Parity: clean store, injected single-bit flip, bypass masks, rewrite.
    cyc(); wr(0, 6, 32'h00000F0F);
    cyc(); rd(0, 6); rd(1, 6);
    expect_rd("par_clean_p0", 0, 32'h00000F0F, 1'b0, 1'b0);
    expect_rd("par_clean_p1", 1, 32'h00000F0F, 1'b0, 1'b0);
    settle();
    dut.mem_q[6] = dut.mem_q[6] ^ 32'h00000001;
    #1;
    expect_rd("par_flip_p0", 0, 32'h00000F0E, 1'b0, 1'b1);
    expect_rd("par_flip_p1", 1, 32'h00000F0E, 1'b0, 1'b1);
    compare_all();
    cyc(); wr(1, 6, 32'h12345678); rd(0, 6);
    expect_rd("par_byp", 0, 32'h12345678, 1'b0, 1'b0);
    settle();
    cyc(); rd(0, 6); rd(1, 6);
    expect_rd("par_rewrite_p0", 0, 32'h12345678, 1'b0, 1'b0);
    expect_rd("par_rewrite_p1", 1, 32'h12345678, 1'b0, 1'b0);
    settle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the next-generation pipelined core. Provides NRD combinational read ports, NWR synchronous write ports, and optional write-to-read bypass. Includes a per-register busy scoreboard, so decode can stall on registers that have an outstanding producer. Sits between decode (reads, reservations) and writeback (writes).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >=2)
NRD, 2, number of read ports (1..4)
NWR, 2, number of write ports (1..2)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read port; 0 = read returns stored value
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
rd_addr  input  NRD*AW  read addresses, port k in bits [k*AW +: AW]; AW = $clog2(NREGS)
rd_data  output  NRD*XLEN  read data, port k in bits [k*XLEN +: XLEN]
rd_busy  output  NRD  busy flag of the register addressed by port k
wr_en  input  NWR  write enable per write port
wr_addr  input  NWR*AW  write addresses
wr_data  input  NWR*XLEN  write data
rsv_en  input  1  reserve request: mark rsv_addr busy
rsv_addr  input  AW  register to reserve
flush  input  1  synchronous clear of all busy bits (pipeline flush)

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high. While rst=1, all registers = 0 and all busy bits = 0. rd_data reflects the zeroed array, so all reads return 0 and all rd_busy are 0.
- Reads are combinational, with zero latency from rd_addr.
- ZERO_REG=1: reads of address 0 return 0 and rd_busy=0. Writes and reservations to address 0 are ignored.
- Writes commit on the rising clk edge when wr_en[j]=1.
- Two write ports targeting the same address in the same cycle: port NWR-1 wins. The data of the losing port is discarded.
- BYPASS=1: if wr_en[j] and wr_addr[j]==rd_addr[k] (and not address 0 under ZERO_REG), rd_data[k] = wr_data[j] in the same cycle. The highest-index matching port has priority. In this case rd_busy[k] = 0, unless a reservation for the same address is also present that cycle.
- BYPASS=0: reads return the pre-edge stored value. rd_busy reflects the pre-edge busy bit.
- Scoreboard, per register, updated on the clk edge:
  - A committed write clears the busy bit.
  - rsv_en sets the busy bit.
  - Write and reservation to the same register in the same cycle: the reservation wins, busy=1 (a new producer is issued).
  - flush=1 clears every busy bit and overrides rsv_en in the same cycle. Writes in a flush cycle still commit their data.
- Out-of-range addresses cannot occur (NREGS is a power of two).
- Reset asserted mid-cycle clears the array and the scoreboard immediately. Writes pending at that edge are lost.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- Defined:
  - Each register stores one extra even-parity bit, computed from the write data on commit.
  - An extra output port rd_perr [NRD] is present. rd_perr[k] = 1 when the stored data and stored parity of the addressed register mismatch.
  - rd_perr is forced to 0 for bypassed reads and for the zero register.
  - Reset sets all parity bits to 0, which is consistent with all-zero data.
- Not defined: no parity storage, and no rd_perr port.

Decomposition:
- Shared package regfile_pkg holds:
  - the AW computation function (clog2 wrapper);
  - the default XLEN/NREGS constants;
  - the parity helper function.
- One sub-module, regfile_scoreboard, holds:
  - the NREGS busy bits;
  - the set/clear/flush priority logic;
  - per-read-port busy lookup.
- The data array, write-port arbitration and bypass muxes stay in regfile_mp.

Test Plan:
- Reset: assert rst for 3 cycles with prior nonzero contents -> every rd_data = 0x00000000 and every rd_busy = 0, immediately and asynchronously.
- Basic write/read: wr port0 writes 0xDEADBEEF to x5. Next cycle rd_addr0=5 -> 0xDEADBEEF. Writing 0x1234 to x0 -> reading x0 returns 0.
- Dual-write conflict: both ports write x7 (port0 0xAAAA0000, port1 0x5555FFFF) -> x7 = 0x5555FFFF. In the same cycle, with BYPASS=1, rd_addr1=7 -> 0x5555FFFF.
- Scoreboard:
  - rsv x3 -> rd_busy=1 on x3 the next cycle.
  - Write x3 -> busy clears on the following cycle.
  - Simultaneous write and rsv on x3 -> stays busy.
- Flush: reserve x1, x2, x4 over 3 cycles, then flush=1 with rsv_en=1 on x9 -> all busy bits 0, including x9. Data in x1/x2/x4 is unchanged.
- Parity (REGFILE_PARITY_EN):
  - Force a single-bit flip in stored x6 via hierarchical poke -> rd_perr=1 on any port reading x6.
  - Rewrite x6 -> rd_perr=0.
